// File: rtl/stlb_arb_pkg.sv
// -----------------------------------------------------------------------------
// stlb_arb_pkg
// Shared types for the shared-TLB lookup arbiter:
//   stlb_owner_e     - which requester owns a lookup (ITLB or DTLB)
//   stlb_arb_state_e - lookup sequencer states
// -----------------------------------------------------------------------------
package stlb_arb_pkg;

    typedef enum logic {
        OWN_ITLB = 1'b0,
        OWN_DTLB = 1'b1
    } stlb_owner_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no lookup pending
        REQ   = 2'd1,   // lookup presented to the shared TLB
        WAIT  = 2'd2,   // lookup accepted, result outstanding
        DRAIN = 2'd3    // flushed while outstanding; result will be dropped
    } stlb_arb_state_e;

endpackage

// File: rtl/stlb_rr_arb2.sv
// -----------------------------------------------------------------------------
// stlb_rr_arb2
// Two-input round-robin picker. On a tie the requester that was not granted
// last wins. The last-granted register moves only when a grant is issued.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset (last-granted -> ITLB)
//   i_en         grants allowed this cycle
//   i_req_itlb   ITLB request
//   i_req_dtlb   DTLB request
//   o_gnt_itlb   ITLB granted (combinational)
//   o_gnt_dtlb   DTLB granted (combinational)
// -----------------------------------------------------------------------------
module stlb_rr_arb2
    import stlb_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_en,
    input  logic i_req_itlb,
    input  logic i_req_dtlb,
    output logic o_gnt_itlb,
    output logic o_gnt_dtlb
);

    stlb_owner_e r_last;
    logic        w_prefer_dtlb;

    // After an ITLB grant the DTLB has priority on the next tie, and vice versa.
    assign w_prefer_dtlb = (r_last == OWN_ITLB);

    assign o_gnt_dtlb = i_en && i_req_dtlb && (!i_req_itlb ||  w_prefer_dtlb);
    assign o_gnt_itlb = i_en && i_req_itlb && (!i_req_dtlb || !w_prefer_dtlb);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last <= OWN_ITLB;
        end else if (o_gnt_dtlb) begin
            r_last <= OWN_DTLB;
        end else if (o_gnt_itlb) begin
            r_last <= OWN_ITLB;
        end
    end

endmodule

// File: rtl/stlb_lookup_arbiter.sv
// -----------------------------------------------------------------------------
// stlb_lookup_arbiter
// Shares the single shared-TLB lookup port between ITLB and DTLB misses.
// One lookup in flight at a time, round-robin between the two requesters,
// responses routed back to the owner; responses orphaned by a flush are dropped.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   flush_i                          TLB flush, aborts pending work
//   asid_i                           current ASID, captured at grant
//   itlb_req_i/itlb_vpn_i            ITLB miss request (held until granted)
//   itlb_gnt_o/itlb_rsp_valid_o      ITLB grant / response strobes
//   dtlb_*                           same for the DTLB
//   rsp_hit_o/rsp_pte_o              response payload, zero unless a strobe is up
//   stlb_req_o/stlb_vpn_o/stlb_asid_o lookup to the shared TLB
//   stlb_gnt_i                       shared TLB accepted the lookup
//   stlb_rsp_valid_i/_hit_i/_pte_i   lookup result
// -----------------------------------------------------------------------------
module stlb_lookup_arbiter
    import stlb_arb_pkg::*;
#(
    parameter int VPN_W  = 20,
    parameter int ASID_W = 9,
    parameter int PTE_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [ASID_W-1:0] asid_i,
    input  logic              itlb_req_i,
    input  logic [VPN_W-1:0]  itlb_vpn_i,
    output logic              itlb_gnt_o,
    output logic              itlb_rsp_valid_o,
    input  logic              dtlb_req_i,
    input  logic [VPN_W-1:0]  dtlb_vpn_i,
    output logic              dtlb_gnt_o,
    output logic              dtlb_rsp_valid_o,
    output logic              rsp_hit_o,
    output logic [PTE_W-1:0]  rsp_pte_o,
    output logic              stlb_req_o,
    output logic [VPN_W-1:0]  stlb_vpn_o,
    output logic [ASID_W-1:0] stlb_asid_o,
    input  logic              stlb_gnt_i,
    input  logic              stlb_rsp_valid_i,
    input  logic              stlb_rsp_hit_i,
    input  logic [PTE_W-1:0]  stlb_rsp_pte_i
);

    stlb_arb_state_e   r_state;
    stlb_arb_state_e   w_state_next;
    stlb_owner_e       r_owner;
    logic [VPN_W-1:0]  r_vpn;
    logic [ASID_W-1:0] r_asid;

    logic w_grant_en;
    logic w_gnt_itlb;
    logic w_gnt_dtlb;
    logic w_any_gnt;
    logic w_deliver;

    // Grants only from IDLE and never during flush or reset, so a requester
    // never sees a grant that the sequencer will not act on.
    assign w_grant_en = (r_state == IDLE) && !flush_i && !rst_i;

    stlb_rr_arb2 u_rr_arb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_en       (w_grant_en),
        .i_req_itlb (itlb_req_i),
        .i_req_dtlb (dtlb_req_i),
        .o_gnt_itlb (w_gnt_itlb),
        .o_gnt_dtlb (w_gnt_dtlb)
    );

    assign w_any_gnt = w_gnt_itlb | w_gnt_dtlb;

    // A result is routed only from WAIT; a same-cycle flush orphans it.
    assign w_deliver = (r_state == WAIT) && stlb_rsp_valid_i && !flush_i && !rst_i;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_gnt) w_state_next = REQ;
            end
            REQ: begin
                // flush beats a same-cycle accept: the lookup counts as never issued
                if (flush_i)         w_state_next = IDLE;
                else if (stlb_gnt_i) w_state_next = WAIT;
            end
            WAIT: begin
                if (stlb_rsp_valid_i) w_state_next = IDLE;
                else if (flush_i)     w_state_next = DRAIN;
            end
            DRAIN: begin
                if (stlb_rsp_valid_i) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_owner <= OWN_ITLB;
            r_vpn   <= '0;
            r_asid  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_any_gnt) begin
                r_owner <= w_gnt_dtlb ? OWN_DTLB : OWN_ITLB;
                r_vpn   <= w_gnt_dtlb ? dtlb_vpn_i : itlb_vpn_i;
                r_asid  <= asid_i;
            end
        end
    end

    assign itlb_gnt_o       = w_gnt_itlb;
    assign dtlb_gnt_o       = w_gnt_dtlb;
    assign itlb_rsp_valid_o = w_deliver && (r_owner == OWN_ITLB);
    assign dtlb_rsp_valid_o = w_deliver && (r_owner == OWN_DTLB);
    assign rsp_hit_o        = w_deliver && stlb_rsp_hit_i;
    assign rsp_pte_o        = w_deliver ? stlb_rsp_pte_i : '0;
    assign stlb_req_o       = (r_state == REQ) && !rst_i;
    assign stlb_vpn_o       = r_vpn;
    assign stlb_asid_o      = r_asid;

endmodule

// File: tb/tb_stlb_lookup_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stlb_lookup_arbiter
// Directed cycle table for the documented scenarios, then randomized traffic
// checked against a lookup-slot reference model.
// -----------------------------------------------------------------------------
module tb_stlb_lookup_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic [8:0]  asid_i;
    logic        itlb_req_i;
    logic [19:0] itlb_vpn_i;
    logic        itlb_gnt_o;
    logic        itlb_rsp_valid_o;
    logic        dtlb_req_i;
    logic [19:0] dtlb_vpn_i;
    logic        dtlb_gnt_o;
    logic        dtlb_rsp_valid_o;
    logic        rsp_hit_o;
    logic [31:0] rsp_pte_o;
    logic        stlb_req_o;
    logic [19:0] stlb_vpn_o;
    logic [8:0]  stlb_asid_o;
    logic        stlb_gnt_i;
    logic        stlb_rsp_valid_i;
    logic        stlb_rsp_hit_i;
    logic [31:0] stlb_rsp_pte_i;

    always #5 clk_i = ~clk_i;

    stlb_lookup_arbiter dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .asid_i           (asid_i),
        .itlb_req_i       (itlb_req_i),
        .itlb_vpn_i       (itlb_vpn_i),
        .itlb_gnt_o       (itlb_gnt_o),
        .itlb_rsp_valid_o (itlb_rsp_valid_o),
        .dtlb_req_i       (dtlb_req_i),
        .dtlb_vpn_i       (dtlb_vpn_i),
        .dtlb_gnt_o       (dtlb_gnt_o),
        .dtlb_rsp_valid_o (dtlb_rsp_valid_o),
        .rsp_hit_o        (rsp_hit_o),
        .rsp_pte_o        (rsp_pte_o),
        .stlb_req_o       (stlb_req_o),
        .stlb_vpn_o       (stlb_vpn_o),
        .stlb_asid_o      (stlb_asid_o),
        .stlb_gnt_i       (stlb_gnt_i),
        .stlb_rsp_valid_i (stlb_rsp_valid_i),
        .stlb_rsp_hit_i   (stlb_rsp_hit_i),
        .stlb_rsp_pte_i   (stlb_rsp_pte_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Output bundle: {ignt, dgnt, req, irsp, drsp, hit, pte[31:0], vpn[19:0], asid[8:0]}
    function automatic logic [66:0] pack(logic gi, logic gd, logic rq, logic ri, logic rd,
                                         logic h, logic [31:0] p, logic [19:0] v, logic [8:0] a);
        return {gi, gd, rq, ri, rd, h, p, v, a};
    endfunction

    function automatic logic [66:0] dut_out();
        return pack(itlb_gnt_o, dtlb_gnt_o, stlb_req_o, itlb_rsp_valid_o, dtlb_rsp_valid_o,
                    rsp_hit_o, rsp_pte_o, stlb_vpn_o, stlb_asid_o);
    endfunction

    task automatic check(string nm, int idx, logic [66:0] exp);
        logic [66:0] act;
        act = dut_out();
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got gi/gd/rq/ri/rd/hit/pte/vpn/asid=%h required %h", nm, idx, act, exp);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst, ireq;
        logic [19:0] ivpn;
        logic        dreq;
        logic [19:0] dvpn;
        logic        flush, sg, sr, hit;
        logic [31:0] pte;
        logic        egi, egd, ereq, eri, erd;
        logic [19:0] evpn;
    } vec_t;

    vec_t tbl[$];

    task automatic add(logic rst, logic ireq, logic [19:0] ivpn, logic dreq, logic [19:0] dvpn,
                       logic flush, logic sg, logic sr, logic hit, logic [31:0] pte,
                       logic egi, logic egd, logic ereq, logic eri, logic erd, logic [19:0] evpn);
        vec_t v;
        v.rst = rst; v.ireq = ireq; v.ivpn = ivpn; v.dreq = dreq; v.dvpn = dvpn;
        v.flush = flush; v.sg = sg; v.sr = sr; v.hit = hit; v.pte = pte;
        v.egi = egi; v.egd = egd; v.ereq = ereq; v.eri = eri; v.erd = erd; v.evpn = evpn;
        tbl.push_back(v);
    endtask

    // ---------------- reference model state ----------------
    // One lookup slot: busy (owned), issued (accepted by shared TLB),
    // orphan (flushed after issue, result to be dropped).
    logic        m_busy, m_issued, m_orphan, m_owner_d, m_last_d;
    logic [19:0] m_vpn;
    logic [8:0]  m_asid;

    initial begin
        logic [66:0] exp;
        logic        ehit;
        logic [31:0] epte;
        logic [8:0]  easid;
        logic        i_pend, d_pend, g_ok, e_gi, e_gd, e_req, dlv;
        logic [19:0] i_vpn, d_vpn;

        rst_i = 1'b1; flush_i = 0; asid_i = 9'h005;
        itlb_req_i = 0; itlb_vpn_i = 0; dtlb_req_i = 0; dtlb_vpn_i = 0;
        stlb_gnt_i = 0; stlb_rsp_valid_i = 0; stlb_rsp_hit_i = 0; stlb_rsp_pte_i = 0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("reset", 0, '0);
        @(posedge clk_i);
        #1;

        // single ITLB request
        add(0,1,'h12345,0,0,      0,0,0,0,0,           1,0,0,0,0,'h0);
        add(0,0,0,0,0,            0,1,0,0,0,           0,0,1,0,0,'h12345);
        add(0,0,0,0,0,            0,0,1,1,'h200000CF,  0,0,0,1,0,'h12345);
        add(0,0,0,0,0,            0,0,0,0,0,           0,0,0,0,0,'h12345);
        // tie after ITLB grant: DTLB first, ITLB right after the DTLB response
        add(0,1,'hAAA,1,'hBBB,    0,0,0,0,0,           0,1,0,0,0,'h12345);
        add(0,1,'hAAA,0,0,        0,1,0,0,0,           0,0,1,0,0,'hBBB);
        add(0,1,'hAAA,0,0,        0,0,1,0,'h11,        0,0,0,0,1,'hBBB);
        add(0,1,'hAAA,0,0,        0,0,0,0,0,           1,0,0,0,0,'hBBB);
        add(0,0,0,0,0,            0,1,0,0,0,           0,0,1,0,0,'hAAA);
        add(0,0,0,0,0,            0,0,1,1,'h22,        0,0,0,1,0,'hAAA);
        // sustained contention: D, I, D, I
        add(0,1,'h101,1,'h202,    0,0,0,0,0,           0,1,0,0,0,'hAAA);
        add(0,1,'h101,1,'h202,    0,1,0,0,0,           0,0,1,0,0,'h202);
        add(0,1,'h101,1,'h202,    0,0,1,0,'h33,        0,0,0,0,1,'h202);
        add(0,1,'h101,1,'h202,    0,0,0,0,0,           1,0,0,0,0,'h202);
        add(0,1,'h101,1,'h202,    0,1,0,0,0,           0,0,1,0,0,'h101);
        add(0,1,'h101,1,'h202,    0,0,1,1,'h44,        0,0,0,1,0,'h101);
        add(0,1,'h101,1,'h202,    0,0,0,0,0,           0,1,0,0,0,'h101);
        add(0,1,'h101,1,'h202,    0,1,0,0,0,           0,0,1,0,0,'h202);
        add(0,1,'h101,1,'h202,    0,0,1,0,'h55,        0,0,0,0,1,'h202);
        add(0,1,'h101,1,'h202,    0,0,0,0,0,           1,0,0,0,0,'h202);
        add(0,1,'h101,1,'h202,    0,1,0,0,0,           0,0,1,0,0,'h101);
        add(0,1,'h101,1,'h202,    0,0,1,1,'h66,        0,0,0,1,0,'h101);
        // flush in WAIT -> DRAIN, result dropped, then DTLB granted
        add(0,1,'h333,0,0,        0,0,0,0,0,           1,0,0,0,0,'h101);
        add(0,0,0,0,0,            0,1,0,0,0,           0,0,1,0,0,'h333);
        add(0,0,0,0,0,            1,0,0,0,0,           0,0,0,0,0,'h333);
        add(0,0,0,1,'h444,        1,0,0,0,0,           0,0,0,0,0,'h333);
        add(0,0,0,1,'h444,        0,0,1,1,'hDEAD,      0,0,0,0,0,'h333);
        add(0,0,0,1,'h444,        0,0,0,0,0,           0,1,0,0,0,'h333);
        add(0,0,0,0,0,            0,1,0,0,0,           0,0,1,0,0,'h444);
        add(0,0,0,0,0,            0,0,1,0,'h77,        0,0,0,0,1,'h444);
        // flush coincident with response in WAIT
        add(0,1,'h555,0,0,        0,0,0,0,0,           1,0,0,0,0,'h444);
        add(0,0,0,0,0,            0,1,0,0,0,           0,0,1,0,0,'h555);
        add(0,0,0,0,0,            1,0,1,1,'hBEEF,      0,0,0,0,0,'h555);
        add(0,0,0,1,'h666,        0,0,0,0,0,           0,1,0,0,0,'h555);
        // flush in REQ with same-cycle accept; stray response in IDLE ignored
        add(0,0,0,0,0,            1,1,0,0,0,           0,0,1,0,0,'h666);
        add(0,0,0,1,'h666,        0,0,1,1,'hCAFE,      0,1,0,0,0,'h666);
        add(0,0,0,0,0,            0,1,0,0,0,           0,0,1,0,0,'h666);
        add(0,0,0,0,0,            0,0,1,1,'h88,        0,0,0,0,1,'h666);
        // reset in WAIT, late response ignored, next tie to DTLB
        add(0,1,'h777,0,0,        0,0,0,0,0,           1,0,0,0,0,'h666);
        add(0,0,0,0,0,            0,1,0,0,0,           0,0,1,0,0,'h777);
        add(1,0,0,0,0,            0,0,0,0,0,           0,0,0,0,0,'h777);
        add(0,0,0,0,0,            0,0,1,1,'hF00D,      0,0,0,0,0,'h0);
        add(0,1,'h888,1,'h999,    0,0,0,0,0,           0,1,0,0,0,'h0);
        add(0,1,'h888,0,0,        0,1,0,0,0,           0,0,1,0,0,'h999);
        add(0,1,'h888,0,0,        0,0,1,1,'h99,        0,0,0,0,1,'h999);

        for (int k = 0; k < tbl.size(); k++) begin
            rst_i = tbl[k].rst; flush_i = tbl[k].flush; asid_i = 9'h005;
            itlb_req_i = tbl[k].ireq; itlb_vpn_i = tbl[k].ivpn;
            dtlb_req_i = tbl[k].dreq; dtlb_vpn_i = tbl[k].dvpn;
            stlb_gnt_i = tbl[k].sg; stlb_rsp_valid_i = tbl[k].sr;
            stlb_rsp_hit_i = tbl[k].hit; stlb_rsp_pte_i = tbl[k].pte;
            // payload is visible only with a strobe; ASID register is 5 once anything was granted
            ehit  = (tbl[k].eri | tbl[k].erd) ? tbl[k].hit : 1'b0;
            epte  = (tbl[k].eri | tbl[k].erd) ? tbl[k].pte : 32'h0;
            easid = (tbl[k].evpn == 20'h0) ? 9'h000 : 9'h005;
            exp = pack(tbl[k].egi, tbl[k].egd, tbl[k].ereq, tbl[k].eri, tbl[k].erd,
                       ehit, epte, tbl[k].evpn, easid);
            @(negedge clk_i);
            check("table", k, exp);
            $display("table row %0d: gi=%0b gd=%0b req=%0b ri=%0b rd=%0b vpn=%h",
                     k, itlb_gnt_o, dtlb_gnt_o, stlb_req_o, itlb_rsp_valid_o, dtlb_rsp_valid_o, stlb_vpn_o);
            @(posedge clk_i);
            #1;
        end

        // ---------------- randomized traffic ----------------
        m_busy = 0; m_issued = 0; m_orphan = 0; m_owner_d = 0; m_last_d = 0;
        m_vpn = 0; m_asid = 0;
        i_pend = 0; d_pend = 0; i_vpn = 0; d_vpn = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rst_i   = (cyc == 0) || ($urandom_range(99) < 2);
            flush_i = ($urandom_range(99) < 6);
            if (i_pend && flush_i && $urandom_range(1) == 1) i_pend = 0;
            if (d_pend && flush_i && $urandom_range(1) == 1) d_pend = 0;
            if (!i_pend && $urandom_range(1) == 1) begin i_pend = 1; i_vpn = 20'($urandom); end
            if (!d_pend && $urandom_range(1) == 1) begin d_pend = 1; d_vpn = 20'($urandom); end
            itlb_req_i = i_pend; itlb_vpn_i = i_vpn;
            dtlb_req_i = d_pend; dtlb_vpn_i = d_vpn;
            asid_i = 9'($urandom);
            stlb_gnt_i = ($urandom_range(1) == 1);
            stlb_rsp_valid_i = ($urandom_range(99) < 40);
            stlb_rsp_hit_i = ($urandom_range(1) == 1);
            stlb_rsp_pte_i = $urandom;

            g_ok  = !m_busy && !flush_i && !rst_i;
            e_gi  = g_ok && i_pend && (!d_pend || m_last_d);
            e_gd  = g_ok && d_pend && (!i_pend || !m_last_d);
            e_req = m_busy && !m_issued && !rst_i;
            dlv   = m_busy && m_issued && !m_orphan && stlb_rsp_valid_i && !flush_i && !rst_i;
            exp = pack(e_gi, e_gd, e_req, dlv && !m_owner_d, dlv && m_owner_d,
                       dlv && stlb_rsp_hit_i, dlv ? stlb_rsp_pte_i : 32'h0, m_vpn, m_asid);

            @(negedge clk_i);
            if (cyc > 0) check("random", cyc, exp);
            if (dlv) $display("random cyc %0d: response to %s vpn=%h pte=%h",
                              cyc, m_owner_d ? "DTLB" : "ITLB", m_vpn, stlb_rsp_pte_i);
            @(posedge clk_i);

            if (rst_i) begin
                m_busy = 0; m_issued = 0; m_orphan = 0; m_last_d = 0; m_vpn = 0; m_asid = 0;
            end else if (!m_busy) begin
                if (e_gi || e_gd) begin
                    m_busy = 1; m_issued = 0; m_orphan = 0; m_owner_d = e_gd; m_last_d = e_gd;
                    m_vpn = e_gd ? d_vpn : i_vpn; m_asid = asid_i;
                end
            end else if (!m_issued) begin
                if (flush_i) m_busy = 0;
                else if (stlb_gnt_i) m_issued = 1;
            end else if (!m_orphan) begin
                if (stlb_rsp_valid_i) m_busy = 0;
                else if (flush_i) m_orphan = 1;
            end else if (stlb_rsp_valid_i) begin
                m_busy = 0;
            end
            if (e_gi) i_pend = 0;
            if (e_gd) d_pend = 0;
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
